circuit_element_writer: RTL and testbench

- Producer side of the element-record RAM that the circuit drawing FSM reads by element index.
- Accepts user-entered elements (node A, node B, type, value) over a valid/ready handshake.
- Validates each entry, packs it into the 24-bit record format and writes it to the RAM.
- Maintains the numElements/numNodes counts and issues the one-cycle start_process pulse that launches drawing.

---
 rtl/circuit_element_writer_pkg.sv | 50 +++++
 rtl/circuit_element_writer_checker.sv | 30 +++
 rtl/circuit_element_writer.sv | 132 +++++++++++++
 tb/tb_circuit_element_writer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/circuit_element_writer_pkg.sv
// Shared definitions for the element-record RAM: field positions, type codes,
// writer states and the record packing function used by writer and drawing datapath.
package circuit_element_writer_pkg;

  localparam int MAX_NODES = 6;

  localparam int NODE_W = 5;
  localparam int TYPE_W = 2;
  localparam int VAL_W  = 10;
  localparam int REC_W  = 24;

  localparam int REC_A_LSB = 19;
  localparam int REC_B_LSB = 14;
  localparam int REC_T_LSB = 10;
  localparam int REC_V_LSB = 0;

  typedef enum logic [1:0] {
    ELEM_VSRC = 2'd0,
    ELEM_CAP  = 2'd1,
    ELEM_RES  = 2'd2,
    ELEM_WIRE = 2'd3
  } elem_type_e;

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_WRITE  = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  typedef struct packed {
    logic [NODE_W-1:0] node_a;
    logic [NODE_W-1:0] node_b;
    elem_type_e        etype;
    logic [VAL_W-1:0]  value;
  } entry_t;

  // Bits [13:12] are reserved and always written as zero.
  function automatic logic [REC_W-1:0] pack_record(input entry_t e);
    logic [REC_W-1:0] r;
    r = '0;
    r[REC_A_LSB +: NODE_W] = e.node_a;
    r[REC_B_LSB +: NODE_W] = e.node_b;
    r[REC_T_LSB +: TYPE_W] = e.etype;
    r[REC_V_LSB +: VAL_W]  = e.value;
    return r;
  endfunction

endpackage

// File: rtl/circuit_element_writer_checker.sv
// Combinational entry validation: accept/reject plus the numNodes value that
// would result from writing this entry.
module circuit_entry_checker #(
  parameter int MAX_ELEMENTS = 16,
  parameter int MAX_NODES    = 6
) (
  input  logic [4:0] node_a,
  input  logic [4:0] node_b,
  input  logic [4:0] num_elements,
  input  logic [4:0] num_nodes,
  output logic       accept,
  output logic [4:0] num_nodes_nxt
);

  localparam logic [4:0] NODE_LIM = 5'(MAX_NODES);
  localparam logic [4:0] ELEM_LIM = 5'(MAX_ELEMENTS);

  logic [4:0] hi_node;
  logic [4:0] span;

  always_comb begin
    hi_node = (node_a > node_b) ? node_a : node_b;
    // Only meaningful on accept, where hi_node < MAX_NODES so +1 cannot wrap.
    span    = hi_node + 5'd1;
    accept  = (node_a != node_b) && (node_a < NODE_LIM) && (node_b < NODE_LIM) &&
              (num_elements != ELEM_LIM);
    num_nodes_nxt = (span > num_nodes) ? span : num_nodes;
  end

endmodule

// File: rtl/circuit_element_writer.sv
// Producer side of the element-record RAM: zero sweep, entry validation and
// write, element/node counts, and the start pulse that launches drawing.
module circuit_element_writer #(
  parameter int MAX_ELEMENTS = 16,
  parameter int MAX_NODES    = circuit_element_writer_pkg::MAX_NODES
) (
  input  logic        clk,
  input  logic        program_resetn,
  input  logic        entry_valid,
  output logic        entry_ready,
  input  logic [4:0]  node_a,
  input  logic [4:0]  node_b,
  input  logic [1:0]  elem_type,
  input  logic [9:0]  elem_value,
  input  logic        clear_req,
  input  logic        commit_req,
  output logic [4:0]  mem_address,
  output logic [23:0] mem_data,
  output logic        mem_wren,
  output logic [4:0]  numElements,
  output logic [4:0]  numNodes,
  output logic        entry_error,
  output logic        start_process,
  output logic        busy
);

  import circuit_element_writer_pkg::*;

  localparam logic [4:0] LAST_ADDR = 5'(MAX_ELEMENTS - 1);

  state_e     state_q, state_d;
  logic [4:0] sweep_q, sweep_d;
  logic [4:0] num_elem_q, num_elem_d;
  logic [4:0] num_nodes_q, num_nodes_d;
  entry_t     entry_q, entry_d;
  logic       wren_raw;
  logic       accept;
  logic [4:0] num_nodes_nxt;

  circuit_entry_checker #(
    .MAX_ELEMENTS (MAX_ELEMENTS),
    .MAX_NODES    (MAX_NODES)
  ) u_checker (
    .node_a        (entry_q.node_a),
    .node_b        (entry_q.node_b),
    .num_elements  (num_elem_q),
    .num_nodes     (num_nodes_q),
    .accept        (accept),
    .num_nodes_nxt (num_nodes_nxt)
  );

  always_ff @(posedge clk or negedge program_resetn) begin
    if (!program_resetn) begin
      state_q     <= ST_CLEAR;
      sweep_q     <= '0;
      num_elem_q  <= '0;
      num_nodes_q <= '0;
      entry_q     <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      num_elem_q  <= num_elem_d;
      num_nodes_q <= num_nodes_d;
      entry_q     <= entry_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sweep_d       = sweep_q;
    num_elem_d    = num_elem_q;
    num_nodes_d   = num_nodes_q;
    entry_d       = entry_q;
    entry_ready   = 1'b0;
    wren_raw      = 1'b0;
    mem_address   = '0;
    mem_data      = '0;
    entry_error   = 1'b0;
    start_process = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        wren_raw    = 1'b1;
        mem_address = sweep_q;
        sweep_d     = sweep_q + 5'd1;
        if (sweep_q == LAST_ADDR) begin
          sweep_d     = '0;
          num_elem_d  = '0;
          num_nodes_d = '0;
          state_d     = ST_IDLE;
        end
      end
      ST_IDLE: begin
        entry_ready = 1'b1;
        if (clear_req)       state_d = ST_CLEAR;
        else if (commit_req) state_d = ST_COMMIT;
        else if (entry_valid) begin
          entry_d = '{node_a, node_b, elem_type_e'(elem_type), elem_value};
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (accept) state_d = ST_WRITE;
        else begin
          entry_error = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_WRITE: begin
        wren_raw    = 1'b1;
        mem_address = num_elem_q;
        mem_data    = pack_record(entry_q);
        num_elem_d  = num_elem_q + 5'd1;
        num_nodes_d = num_nodes_nxt;
        state_d     = ST_IDLE;
      end
      ST_COMMIT: begin
        if (num_elem_q == 5'd0) entry_error   = 1'b1;
        else                    start_process = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Reset parks the FSM in CLEAR; mask the write strobe so the RAM sees no
  // write while reset is held.
  assign mem_wren    = wren_raw & program_resetn;
  assign numElements = num_elem_q;
  assign numNodes    = num_nodes_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_circuit_element_writer.sv
// Randomized bench for circuit_element_writer: each operation pushes the cycle-by-cycle
// outputs it must produce into a queue, and a negedge process compares the DUT against it.
module tb_circuit_element_writer;

  localparam int MAXE = 16;
  localparam int MAXN = 6;

  logic        clk = 1'b0;
  logic        program_resetn;
  logic        entry_valid, entry_ready;
  logic [4:0]  node_a, node_b;
  logic [1:0]  elem_type;
  logic [9:0]  elem_value;
  logic        clear_req, commit_req;
  logic [4:0]  mem_address;
  logic [23:0] mem_data;
  logic        mem_wren;
  logic [4:0]  numElements, numNodes;
  logic        entry_error, start_process, busy;

  always #5 clk = ~clk;

  circuit_element_writer #(.MAX_ELEMENTS(MAXE), .MAX_NODES(MAXN)) dut (
    .clk(clk), .program_resetn(program_resetn),
    .entry_valid(entry_valid), .entry_ready(entry_ready),
    .node_a(node_a), .node_b(node_b), .elem_type(elem_type), .elem_value(elem_value),
    .clear_req(clear_req), .commit_req(commit_req),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .numElements(numElements), .numNodes(numNodes),
    .entry_error(entry_error), .start_process(start_process), .busy(busy)
  );

  typedef struct {
    logic        ready, wren;
    logic [4:0]  addr;
    logic [23:0] data;
    logic        err, start, busy;
    logic [4:0]  ne, nn;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   vectors = 0, miscompares = 0;
  bit   chk_en = 1'b0;
  int   m_n = 0, m_nodes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [23:0] model_rec(input int a, input int b, input int t, input int v);
    return {a[4:0], b[4:0], 2'b00, t[1:0], v[9:0]};
  endfunction

  function automatic exp_t mk(input bit ready, input bit wren, input int addr,
                              input logic [23:0] data, input bit err, input bit start,
                              input bit bsy);
    exp_t e;
    e.ready = ready; e.wren = wren; e.addr = addr[4:0]; e.data = data;
    e.err = err; e.start = start; e.busy = bsy;
    e.ne = m_n[4:0]; e.nn = m_nodes[4:0];
    return e;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() == 0) chk("exp_underflow", 1, 0);
      else begin
        cur = exp_q.pop_front();
        chk("entry_ready", entry_ready, cur.ready);
        chk("mem_wren", mem_wren, cur.wren);
        if (cur.wren) begin
          chk("mem_address", mem_address, cur.addr);
          chk("mem_data", mem_data, cur.data);
        end
        chk("entry_error", entry_error, cur.err);
        chk("start_process", start_process, cur.start);
        chk("busy", busy, cur.busy);
        chk("numElements", numElements, cur.ne);
        chk("numNodes", numNodes, cur.nn);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_in(input bit v, input int a, input int b, input int t, input int val,
                        input bit clr, input bit cmt);
    entry_valid = v; node_a = a[4:0]; node_b = b[4:0]; elem_type = t[1:0];
    elem_value = val[9:0]; clear_req = clr; commit_req = cmt;
  endtask

  // Inputs outside IDLE must be ignored, so drive noise there.
  task automatic garbage();
    set_in($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 3), $urandom_range(0, 1023), $urandom_range(0, 1),
           $urandom_range(0, 1));
  endtask

  task automatic push_idle();
    exp_q.push_back(mk(1, 0, 0, 24'h0, 0, 0, 0));
  endtask

  task automatic push_clear();
    for (int i = 0; i < MAXE; i++) exp_q.push_back(mk(0, 1, i, 24'h0, 0, 0, 1));
    m_n = 0; m_nodes = 0;
  endtask

  task automatic do_entry(input int a, input int b, input int t, input int v);
    bit rej;
    int hi;
    set_in(1, a, b, t, v, 0, 0);
    push_idle();
    rej = (a == b) || (a >= MAXN) || (b >= MAXN) || (m_n == MAXE);
    exp_q.push_back(mk(0, 0, 0, 24'h0, rej, 0, 1));
    if (!rej) begin
      exp_q.push_back(mk(0, 1, m_n, model_rec(a, b, t, v), 0, 0, 1));
      hi = (a > b) ? a : b;
      m_n++;
      if (hi + 1 > m_nodes) m_nodes = hi + 1;
    end
    tick(); garbage(); tick();
    if (!rej) begin garbage(); tick(); end
  endtask

  task automatic do_commit();
    set_in($urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 5), 0, 0, 0, 1);
    push_idle();
    exp_q.push_back(mk(0, 0, 0, 24'h0, m_n == 0, m_n != 0, 1));
    tick(); garbage(); tick();
  endtask

  task automatic do_clear(input bit cmt);
    set_in($urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 5), 0, 0, 1, cmt);
    push_idle();
    push_clear();
    tick();
    repeat (MAXE) begin garbage(); tick(); end
  endtask

  task automatic do_idle();
    set_in(0, $urandom_range(0, 31), $urandom_range(0, 31), 0, 0, 0, 0);
    push_idle();
    tick();
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    program_resetn = 1'b1;
    push_clear();
    chk_en = 1'b1;
    repeat (MAXE) begin garbage(); tick(); end
  endtask

  initial begin
    int r, a, b;
    program_resetn = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_entry_ready", entry_ready, 0);
    chk("rst_entry_error", entry_error, 0);
    chk("rst_start_process", start_process, 0);
    chk("rst_numElements", numElements, 0);
    chk("rst_numNodes", numNodes, 0);
    release_reset();
    chk("post_sweep_ready", entry_ready, 1);
    chk("post_sweep_numElements", numElements, 0);
    chk("post_sweep_numNodes", numNodes, 0);

    do_entry(0, 3, 2, 470);
    chk("pack_literal", model_rec(0, 3, 2, 470), 24'h00C9D6);
    chk("first_numElements", numElements, 1);
    chk("first_numNodes", numNodes, 4);
    do_entry(2, 2, 1, 5);
    do_entry(6, 1, 0, 7);
    chk("rejects_numElements", numElements, 1);
    chk("rejects_numNodes", numNodes, 4);

    for (int i = 0; i < MAXE - 1; i++) do_entry(i % MAXN, (i + 1) % MAXN, i % 4, i * 37);
    chk("full_numElements", numElements, 16);
    do_entry(1, 2, 3, 99);
    chk("overflow_numElements", numElements, 16);

    do_clear(1);
    chk("clear_wins_numElements", numElements, 0);
    do_commit();
    do_entry(4, 5, 3, 1023);
    do_commit();
    do_idle();

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        a = ($urandom_range(0, 9) == 0) ? $urandom_range(MAXN, 31) : $urandom_range(0, MAXN - 1);
        b = ($urandom_range(0, 9) == 0) ? $urandom_range(MAXN, 31) : $urandom_range(0, MAXN - 1);
        do_entry(a, b, $urandom_range(0, 3), $urandom_range(0, 1023));
      end else if (r < 72) do_commit();
      else if (r < 77) do_clear($urandom_range(0, 1));
      else do_idle();
    end

    do_clear(0);
    set_in(1, 1, 4, 0, 12, 0, 0);
    push_idle();
    exp_q.push_back(mk(0, 0, 0, 24'h0, 0, 0, 1));
    exp_q.push_back(mk(0, 1, 0, model_rec(1, 4, 0, 12), 0, 0, 1));
    tick(); garbage(); tick();
    @(negedge clk); #1;
    chk_en = 1'b0;
    program_resetn = 1'b0;
    #1;
    chk("midwrite_rst_mem_wren", mem_wren, 0);
    chk("midwrite_rst_mem_address", mem_address, 0);
    chk("midwrite_rst_numElements", numElements, 0);
    chk("midwrite_rst_entry_ready", entry_ready, 0);
    m_n = 0; m_nodes = 0;
    release_reset();
    do_idle();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
